// File: rtl/tff_toggle_gen.sv
// tff_toggle_gen: programmable strobe generator driving a T flip-flop's toggle-enable input
module tff_toggle_gen #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               data,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, per_l, per_n;
  logic [BURST_W-1:0] len_l, pc_n;
  assign per_n = (period == '0) ? CNT_W'(1) : period;
  assign pc_n  = pulse_cnt + BURST_W'(1);
  assign busy  = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      cnt       <= '0;
      per_l     <= '0;
      len_l     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          data <= 1'b0;
          if (start) begin
            per_l     <= per_n;
            len_l     <= burst_len;
            cnt       <= per_n - CNT_W'(1);
            pulse_cnt <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          // stop wins over a strobe falling due on the same edge
          if (stop) begin
            data  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            data      <= 1'b1;
            cnt       <= per_l - CNT_W'(1);
            pulse_cnt <= pc_n;
            if (len_l != '0 && pc_n == len_l) state <= DONE;
          end else begin
            data <= 1'b0;
            cnt  <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          data  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
